// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters; one transfer per grant.
// Optional SPI_ARB_BURST_EN adds i_lock for back-to-back bytes from a single owner.
module spi_request_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_tx_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic                          o_err,
  output logic [DATA_WIDTH-1:0]         o_rx_data,
  output logic                          o_spi_enable,
  output logic [DATA_WIDTH-1:0]         o_master_tx_datain,
  input  logic                          i_busy,
  input  logic [DATA_WIDTH-1:0]         i_master_rx_dataout
`ifdef SPI_ARB_BURST_EN
  ,
  input  logic [NUM_REQ-1:0]            i_lock
`endif
);

  // state     | meaning
  // S_IDLE    | sample req, pick next owner round-robin
  // S_START   | one-cycle spi_enable, load busy-start timer
  // S_WAIT    | wait for busy to rise, time out after BUSY_TIMEOUT cycles
  // S_XFER    | wait for busy to fall, capture received byte
  // S_DONE    | one-cycle ack/err to owner, update round-robin pointer

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_XFER, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         r_last;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  r_err;
  logic [TW-1:0]         r_timer;
  logic [IW:0]           w_pick;
  logic                  w_burst;

  // Returns {found, index} of the first requester after 'last', wrapping around.
  function automatic logic [IW:0] f_pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] last);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (req[j[IW-1:0]]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pick       = f_pick(i_req, r_last);
    w_burst      = 1'b0;
    o_spi_enable = 1'b0;
    o_ack        = '0;
    o_err        = 1'b0;
`ifdef SPI_ARB_BURST_EN
    w_burst      = i_lock[r_owner] & i_req[r_owner];
`endif
    case (r_state)
      S_IDLE:  if (w_pick[IW]) w_state_nxt = S_START;
      S_START: begin
        o_spi_enable = 1'b1;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_busy)              w_state_nxt = S_XFER;
        else if (r_timer == '0)  w_state_nxt = S_DONE;
      end
      S_XFER:  if (!i_busy) w_state_nxt = S_DONE;
      S_DONE: begin
        o_ack       = r_grant;
        o_err       = r_err;
        w_state_nxt = w_burst ? S_START : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_tx    <= '0;
      r_rx    <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick[IW]) begin
            r_owner <= w_pick[IW-1:0];
            r_grant <= NUM_REQ'(1) << w_pick[IW-1:0];
            r_tx    <= i_req_tx_data[int'(w_pick[IW-1:0])*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_START: begin
          // Down-counter expires so the timeout ack lands BUSY_TIMEOUT cycles after spi_enable.
          r_timer <= TW'(BUSY_TIMEOUT - 2);
          r_err   <= 1'b0;
        end
        S_WAIT: begin
          if (!i_busy) begin
            if (r_timer == '0) r_err <= 1'b1;
            else               r_timer <= r_timer - 1'b1;
          end
        end
        S_XFER: begin
          if (!i_busy) begin
            r_rx  <= i_master_rx_dataout;
            r_err <= 1'b0;
          end
        end
        S_DONE: begin
          r_last <= r_owner;
          if (w_burst) r_tx <= i_req_tx_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
          else         r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_grant            = r_grant;
  assign o_rx_data          = r_rx;
  assign o_master_tx_datain = r_tx;

endmodule
